universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; legal values are 2 and above.
REQ-002 Parameter: AMT_W, default $clog2(WIDTH), width of the shift-amount field; legal values are 1 and above.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  operation request; sampled only while busy=0.
REQ-006 op  input  3  operation code; captured at accept.
REQ-007 amt  input  AMT_W  shift/rotate count 0..2^AMT_W-1; captured at accept.
REQ-008 d  input  WIDTH  parallel load data; sampled at accept.
REQ-009 sin  input  1  serial fill bit for logical shifts; sampled live on every shift edge.
REQ-010 q  output  WIDTH  register contents.
REQ-011 sout  output  1  last bit shifted or rotated out.
REQ-012 busy  output  1  high while a multi-step operation is in progress.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 Op codes SHALL be as follows:
- 000 LOAD (q<=d)
- 001 SHL (q<={q[W-2:0],sin})
- 010 SHR (q<={sin,q[W-1:1]})
- 011 ASR (q<={q[W-1],q[W-1:1]})
- 100 ROL
- 101 ROR
- 110 CLEAR (q<=0)
- 111 NOP
REQ-015 A request SHALL be accepted on a rising edge where start=1 and busy=0; start while busy=1 SHALL be ignored without side effects.
REQ-016 LOAD, CLEAR and NOP SHALL complete on the accepting edge: q updated, done=1 for the following cycle, and busy remains 0.
REQ-017 Shift/rotate ops with amt=N>=1 SHALL perform exactly one single-bit step per edge, the first on the accepting edge, for N consecutive edges.
REQ-018 A remaining-step counter SHALL be loaded with N-1 at accept; busy SHALL be 1 from the edge after accept while the count is nonzero; the N-th step edge clears busy and sets done for one cycle.
REQ-019 Shift/rotate with amt=0 SHALL leave q and sout unchanged and pulse done on the cycle after accept; busy remains 0.
REQ-020 State machine: IDLE (busy=0) and SHIFT (busy=1).
- IDLE->SHIFT on accept of a shift/rotate op with N>=2.
- SHIFT->IDLE on the edge executing the final step.
REQ-021 sout SHALL be updated on every shift/rotate step:
- left ops: old q[WIDTH-1]
- right ops: old q[0]
- rotates: the wrapped bit
LOAD, CLEAR and NOP SHALL leave sout unchanged.
REQ-022 ASR SHALL replicate the MSB and ignore sin; rotates SHALL ignore sin.
REQ-023 amt >= WIDTH SHALL be legal: logical shifts saturate to all-sin fill, ASR to all-sign, and rotates wrap modulo WIDTH by stepping.
REQ-024 done SHALL be high at most one cycle per accepted request; back-to-back requests are legal, and start during the done cycle SHALL be accepted.
REQ-025 op, amt and d SHALL be held internally from accept; changes during busy SHALL NOT affect the running operation.

Reset
REQ-026 reset_n=0 SHALL immediately force q=0, sout=0, busy=0, done=0, counter=0 and state=IDLE, independent of clk.
REQ-027 Reset asserted mid-operation SHALL abort it with no done pulse; after release the block SHALL accept a new start on the first edge.

Verification
REQ-028 Reset with WIDTH=8 -> q=8'h00, sout=0, busy=0, done=0; reset deasserted with start=0 -> all outputs hold.
REQ-029 LOAD with d=8'hA5 -> q=8'hA5 after 1 edge, done=1 for 1 cycle, busy never 1; then CLEAR -> q=8'h00.
REQ-030 q=8'h81, SHL amt=3, sin=1 -> q=8'h03, 8'h07, 8'h0F on successive edges; sout=1, then 0, then 0; busy=1 for 2 cycles; done follows on the cycle after the third step.
REQ-031 q=8'h90, ASR amt=2 -> 8'hC8 then 8'hE4, sout=0; q=8'h01, ROR amt=1 -> q=8'h80, sout=1, done next cycle, busy stays 0.
REQ-032 Start SHR amt=5, with start re-asserted and op/d changed while busy -> ignored; result equals 5 steps of the original op; amt=0 -> q unchanged, done pulses once.
REQ-033 Reset asserted during the 3rd step of ROL amt=6 -> q=0, busy=0, no done pulse; LOAD on the first edge after release -> accepted.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: load/clear/nop in one edge, shifts and rotates
// step one bit per edge for amt edges, with a busy window and a done pulse.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_SHL   = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_ASR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [AMT_W-1:0] ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] ZERO = '0;

  logic [0:0]       state;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic [2:0]       cur_op;
  logic [WIDTH-1:0] nq;
  logic             nsout;

  assign busy = (state == S_SHIFT);

  // The accepting edge steps with the live op; later edges use the captured op.
  assign cur_op = (state == S_SHIFT) ? op_r : op;

  always_comb begin
    nq    = q;
    nsout = sout;
    case (cur_op)
      OP_SHL: begin
        nq    = {q[WIDTH-2:0], sin};
        nsout = q[WIDTH-1];
      end
      OP_SHR: begin
        nq    = {sin, q[WIDTH-1:1]};
        nsout = q[0];
      end
      OP_ASR: begin
        nq    = {q[WIDTH-1], q[WIDTH-1:1]};
        nsout = q[0];
      end
      OP_ROL: begin
        nq    = {q[WIDTH-2:0], q[WIDTH-1]};
        nsout = q[WIDTH-1];
      end
      OP_ROR: begin
        nq    = {q[0], q[WIDTH-1:1]};
        nsout = q[0];
      end
      default: begin
        nq    = q;
        nsout = sout;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q     <= '0;
      sout  <= 1'b0;
      done  <= 1'b0;
      cnt   <= ZERO;
      op_r  <= OP_NOP;
      state <= S_IDLE;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r <= op;
            case (op)
              OP_LOAD: begin
                q    <= d;
                done <= 1'b1;
              end
              OP_CLEAR: begin
                q    <= '0;
                done <= 1'b1;
              end
              OP_NOP: begin
                done <= 1'b1;
              end
              default: begin
                if (amt == ZERO) begin
                  done <= 1'b1;
                  cnt  <= ZERO;
                end else begin
                  q    <= nq;
                  sout <= nsout;
                  cnt  <= amt - ONE;
                  if (amt == ONE) begin
                    done <= 1'b1;
                  end else begin
                    state <= S_SHIFT;
                  end
                end
              end
            endcase
          end
        end
        S_SHIFT: begin
          q    <= nq;
          sout <= nsout;
          cnt  <= cnt - ONE;
          if (cnt == ONE) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, AMT_W=4 so amt>=WIDTH is reachable).
module tb_universal_shift_reg;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] op;
  logic [3:0] amt;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  universal_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .d       (d),
    .sin     (sin),
    .q       (q),
    .sout    (sout),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] dd);
    op    = o;
    amt   = a;
    d     = dd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'b111;
    amt     = 4'd0;
    d       = 8'h00;
    sin     = 1'b0;
    #3;
    chk("rst_q", q, 8'h00);
    chk("rst_sout", sout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_q", q, 8'h00);
    chk("idle_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // LOAD then CLEAR
    issue(3'b000, 4'd0, 8'hA5);
    chk("load_q", q, 8'hA5);
    chk("load_done", done, 1'b1);
    chk("load_busy", busy, 1'b0);
    tick();
    chk("load_done_drop", done, 1'b0);
    issue(3'b110, 4'd0, 8'hFF);
    chk("clear_q", q, 8'h00);
    chk("clear_done", done, 1'b1);
    tick();

    // SHL amt=3, issued in the done cycle of the preceding LOAD
    sin = 1'b1;
    issue(3'b000, 4'd0, 8'h81);
    chk("load81_q", q, 8'h81);
    issue(3'b001, 4'd3, 8'h00);
    chk("shl_s1_q", q, 8'h03);
    chk("shl_s1_sout", sout, 1'b1);
    chk("shl_s1_busy", busy, 1'b1);
    chk("shl_s1_done", done, 1'b0);
    tick();
    chk("shl_s2_q", q, 8'h07);
    chk("shl_s2_sout", sout, 1'b0);
    chk("shl_s2_busy", busy, 1'b1);
    tick();
    chk("shl_s3_q", q, 8'h0F);
    chk("shl_s3_sout", sout, 1'b0);
    chk("shl_s3_busy", busy, 1'b0);
    chk("shl_s3_done", done, 1'b1);
    tick();
    chk("shl_done_drop", done, 1'b0);

    // ASR ignores sin
    issue(3'b000, 4'd0, 8'h90);
    issue(3'b011, 4'd2, 8'h00);
    chk("asr_s1_q", q, 8'hC8);
    chk("asr_s1_sout", sout, 1'b0);
    chk("asr_s1_busy", busy, 1'b1);
    tick();
    chk("asr_s2_q", q, 8'hE4);
    chk("asr_s2_sout", sout, 1'b0);
    chk("asr_s2_done", done, 1'b1);
    tick();

    // ROR amt=1: single step, never busy
    issue(3'b000, 4'd0, 8'h01);
    issue(3'b101, 4'd1, 8'h00);
    chk("ror_q", q, 8'h80);
    chk("ror_sout", sout, 1'b1);
    chk("ror_done", done, 1'b1);
    chk("ror_busy", busy, 1'b0);
    tick();
    chk("ror_done_drop", done, 1'b0);

    // LOAD leaves sout alone; SHR amt=5 with start/op/d disturbed while busy
    sin = 1'b0;
    issue(3'b000, 4'd0, 8'hB6);
    chk("load_keeps_sout", sout, 1'b1);
    issue(3'b010, 4'd5, 8'h00);
    chk("shr_s1_q", q, 8'h5B);
    start = 1'b1;
    op    = 3'b000;
    d     = 8'hFF;
    amt   = 4'd1;
    tick();
    chk("shr_s2_q", q, 8'h2D);
    chk("shr_s2_busy", busy, 1'b1);
    tick();
    chk("shr_s3_q", q, 8'h16);
    start = 1'b0;
    tick();
    chk("shr_s4_q", q, 8'h0B);
    chk("shr_s4_done", done, 1'b0);
    tick();
    chk("shr_s5_q", q, 8'h05);
    chk("shr_s5_sout", sout, 1'b1);
    chk("shr_s5_done", done, 1'b1);
    chk("shr_s5_busy", busy, 1'b0);
    tick();
    chk("shr_hold_q", q, 8'h05);
    chk("shr_done_drop", done, 1'b0);

    // amt=0: no change, single done pulse
    sin = 1'b1;
    issue(3'b001, 4'd0, 8'h00);
    chk("amt0_q", q, 8'h05);
    chk("amt0_sout", sout, 1'b1);
    chk("amt0_done", done, 1'b1);
    chk("amt0_busy", busy, 1'b0);
    tick();
    chk("amt0_done_drop", done, 1'b0);

    // amt beyond WIDTH: SHL saturates to sin fill, ROL wraps modulo 8
    issue(3'b000, 4'd0, 8'h5A);
    issue(3'b001, 4'd9, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    chk("shl9_q", q, 8'hFF);
    chk("shl9_sout", sout, 1'b1);
    chk("shl9_done", done, 1'b1);
    sin = 1'b0;
    issue(3'b000, 4'd0, 8'hA5);
    issue(3'b100, 4'd9, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    chk("rol9_q", q, 8'h4B);
    chk("rol9_sout", sout, 1'b1);
    chk("rol9_done", done, 1'b1);
    tick();

    // Reset during ROL amt=6 aborts without done
    issue(3'b000, 4'd0, 8'h3C);
    issue(3'b100, 4'd6, 8'h00);
    chk("rol_s1_q", q, 8'h78);
    tick();
    chk("rol_s2_q", q, 8'hF0);
    reset_n = 1'b0;
    #1;
    chk("abort_q", q, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_sout", sout, 1'b0);
    tick();
    chk("abort_done", done, 1'b0);
    tick();
    reset_n = 1'b1;
    issue(3'b000, 4'd0, 8'hC3);
    chk("post_rst_q", q, 8'hC3);
    chk("post_rst_done", done, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
